t1_stencil_window: RTL
======================

T1_STENCIL_WINDOW -- requirements
Module: t1_stencil_window

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 32, frame width in pixels (>=3).
REQ-003 SHALL have parameter IMG_H, default 32, frame height in pixels (>=3).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports start input 1 (begin frame) and done output 1 (frame-complete pulse).
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_W: raster-order t1 pixel stream.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_c/out_n/out_s/out_w/out_e output DATA_W each: 5-point window feeding the jacobi update op.
REQ-009 SHALL have port out_last output 1, high with the final window of the frame.

Function
REQ-010 SHALL implement FSM IDLE -> RUN on start=1 in IDLE; RUN -> DONE when last input accepted and final window accepted; DONE -> IDLE after exactly one cycle.
REQ-011 SHALL ignore start outside IDLE.
REQ-012 SHALL drive done=1 only in DONE (one-cycle pulse).
REQ-013 SHALL accept input on in_valid & in_ready; in_ready = (state==RUN) & inputs_remaining & (!out_valid | out_ready).
REQ-014 SHALL track input column x (0..IMG_W-1) and row y (0..IMG_H-1), x wraps to 0 and y increments on x==IMG_W-1.
REQ-015 SHALL keep two row buffers (rows y-1, y-2) of IMG_W words, read-before-write at column x, plus a 2-deep shift register per row.
REQ-016 SHALL produce a window when pixel (x,y) is accepted with x>=2 and y>=2: c=(x-1,y-1), n=(x-1,y-2), s=(x-1,y), w=(x-2,y-1), e=(x,y-1).
REQ-017 SHALL register the window: out_valid rises the cycle after the triggering input is accepted (latency 1).
REQ-018 SHALL hold out_* stable while out_valid & !out_ready; out_valid clears on acceptance unless a new window loads same cycle.
REQ-019 SHALL emit exactly (IMG_W-2)*(IMG_H-2) windows per frame, out_last on the last one.
REQ-020 SHALL emit no window for border pixels (x<2 or y<2); those only fill buffers.
REQ-021 SHALL pass data unmodified (no arithmetic, no width change).

Reset
REQ-022 SHALL on rst=0 immediately force: state=IDLE, x=y=0, out_valid=0, out_last=0, done=0, in_ready=0, out_* data=0.
REQ-023 SHALL not require row-buffer contents cleared; stale data is never emitted since rows refill before use.
REQ-024 SHALL abandon any frame in progress on reset and require a new start.

Structure
REQ-025 SHALL place DATA_W/IMG_W/IMG_H defaults, the FSM state enum and a window struct {c,n,s,w,e} in shared package jacobi2d_pkg.
REQ-026 SHALL instantiate sub-module t1_row_buf (IMG_W x DATA_W, one read+write port, read-before-write) twice.
REQ-027 SHALL fit in 120-400 lines of RTL total.

Verification (IMG_W=IMG_H=4, in_data=4*y+x unless noted)
REQ-028 SHALL cover: start, stream 16 pixels, out_ready=1 -> 4 windows; first c=5,n=1,s=9,w=4,e=6; last c=10,n=6,s=14,w=9,e=11 with out_last=1; done pulses once.
REQ-029 SHALL cover: out_ready=0 for 3 cycles at first window -> out_* held at c=5, in_ready=0 those cycles, no window lost or duplicated.
REQ-030 SHALL cover: rst=0 asserted after pixel 7 -> outputs zero immediately, state IDLE; new start and full frame -> same 4 windows as REQ-028.
REQ-031 SHALL cover: start pulsed mid-frame -> ignored, window sequence unchanged.
REQ-032 SHALL cover: random in_valid/out_ready gaps (50%) -> window sequence identical to REQ-028, done exactly once after last acceptance.
REQ-033 SHALL cover: in_valid=1 while IDLE -> in_ready=0, nothing accepted, out_valid stays 0.

Source files
------------

// File: rtl/jacobi2d_pkg.sv
// ---------------------------------------------------------------------------
// jacobi2d_pkg
// Shared definitions for the jacobi 2-D stencil front end:
//   - default pixel width and frame geometry
//   - frame-control FSM state encoding
//   - 5-point window layout {c, n, s, w, e} at the default pixel width
// ---------------------------------------------------------------------------
package jacobi2d_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IMG_W  = 32;
  localparam int DEF_IMG_H  = 32;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    RUN_ST  = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  // Canonical window layout at the default width; modules built with a
  // different DATA_W mirror this field order locally.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] c;
    logic [DEF_DATA_W-1:0] n;
    logic [DEF_DATA_W-1:0] s;
    logic [DEF_DATA_W-1:0] w;
    logic [DEF_DATA_W-1:0] e;
  } window_t;

endpackage

// File: rtl/t1_row_buf.sv
// ---------------------------------------------------------------------------
// t1_row_buf
// One image row of storage, single read+write port addressed by column.
// The read is combinational from the current contents, so a read and a write
// to the same column in one cycle return the old word (read-before-write).
// Contents are not reset: every column is rewritten before it is consumed.
//   clk   : clock
//   we    : write enable
//   addr  : column address
//   wdata : word written at addr on the rising edge when we=1
//   rdata : word currently stored at addr
// ---------------------------------------------------------------------------
module t1_row_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Row storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/t1_stencil_window.sv
// ---------------------------------------------------------------------------
// t1_stencil_window
// Turns a raster-order pixel stream into 5-point (c,n,s,w,e) windows for the
// jacobi update. Two row buffers hold rows y-1 and y-2; short shift registers
// supply the x-1 / x-2 neighbours. A window is produced for every interior
// centre; border pixels only fill the buffers.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   start     : begin a frame (honoured in IDLE only)
//   done      : one-cycle pulse after the final window is accepted
//   in_valid / in_ready / in_data : pixel input handshake
//   out_valid / out_ready         : window output handshake
//   out_c/n/s/w/e                 : registered window
//   out_last  : marks the final window of the frame
// ---------------------------------------------------------------------------
module t1_stencil_window
  import jacobi2d_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_n,
  output logic [DATA_W-1:0] out_s,
  output logic [DATA_W-1:0] out_w,
  output logic [DATA_W-1:0] out_e,
  output logic              out_last
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  typedef struct packed {
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] e;
  } win_t;

  state_e            state_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic              in_left_r;
  logic              done_r;
  logic              out_valid_r;
  logic              out_last_r;
  win_t              win_r;

  // Neighbour taps: r0 = current row, r1 = row y-1, r2 = row y-2.
  logic [DATA_W-1:0] r0_d1_r;
  logic [DATA_W-1:0] r1_d1_r;
  logic [DATA_W-1:0] r1_d2_r;
  logic [DATA_W-1:0] r2_d1_r;

  logic [DATA_W-1:0] row1_rd_s;
  logic [DATA_W-1:0] row2_rd_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              last_px_s;
  logic              win_fire_s;
  logic              out_fire_s;

  // A new input is only taken when the output register is free (or being
  // drained this cycle), so a produced window can never overwrite one that
  // is still waiting.
  assign in_ready_s = (state_r == RUN_ST) & in_left_r & (~out_valid_r | out_ready);
  assign accept_s   = in_valid & in_ready_s;
  assign last_px_s  = (x_r == X_LAST) & (y_r == Y_LAST);
  assign win_fire_s = accept_s & (x_r >= X_TWO) & (y_r >= Y_TWO);
  assign out_fire_s = out_valid_r & out_ready;

  // Row y-1 takes the incoming pixel; row y-2 takes what row y-1 held.
  t1_row_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(XW)) u_row1 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (x_r),
    .wdata (in_data),
    .rdata (row1_rd_s)
  );

  t1_row_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(XW)) u_row2 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (x_r),
    .wdata (row1_rd_s),
    .rdata (row2_rd_s)
  );

  // Frame-control FSM with column/row counters and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE_ST;
      x_r       <= '0;
      y_r       <= '0;
      in_left_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE_ST: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= RUN_ST;
            x_r       <= '0;
            y_r       <= '0;
            in_left_r <= 1'b1;
          end else begin
            state_r <= IDLE_ST;
          end
        end
        RUN_ST: begin
          if (accept_s) begin
            if (x_r == X_LAST) begin
              x_r <= '0;
              y_r <= (y_r == Y_LAST) ? '0 : y_r + YW'(1);
            end else begin
              x_r <= x_r + XW'(1);
            end
            if (last_px_s) begin
              in_left_r <= 1'b0;
            end else begin
              in_left_r <= in_left_r;
            end
          end else begin
            x_r <= x_r;
          end
          if (!in_left_r && out_fire_s && out_last_r) begin
            state_r <= DONE_ST;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN_ST;
            done_r  <= 1'b0;
          end
        end
        DONE_ST: begin
          state_r <= IDLE_ST;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE_ST;
          in_left_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Neighbour shift registers and the registered output window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_d1_r     <= '0;
      r1_d1_r     <= '0;
      r1_d2_r     <= '0;
      r2_d1_r     <= '0;
      win_r       <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        r0_d1_r <= in_data;
        r1_d1_r <= row1_rd_s;
        r1_d2_r <= r1_d1_r;
        r2_d1_r <= row2_rd_s;
      end
      if (win_fire_s) begin
        win_r.c     <= r1_d1_r;
        win_r.n     <= r2_d1_r;
        win_r.s     <= r0_d1_r;
        win_r.w     <= r1_d2_r;
        win_r.e     <= row1_rd_s;
        out_valid_r <= 1'b1;
        out_last_r  <= last_px_s;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign done      = done_r;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_c     = win_r.c;
  assign out_n     = win_r.n;
  assign out_s     = win_r.s;
  assign out_w     = win_r.w;
  assign out_e     = win_r.e;

endmodule
